stage4_mem_access: RTL and testbench

- Pipeline stage 4, the data-memory access stage. Sits directly downstream of the execute stage.
- Consumes the ALU result (`eval`), the store data and the memory-op decode for one instruction.
- Issues at most one request on a req/ready/rvalid data-memory port and produces the writeback value for stage 5.
- Holds the pipeline via `mem_busy` while a memory transaction is outstanding.

---
 rtl/stage4_mem_access.sv | 199 +++++++++++++++++++
 tb/tb_stage4_mem_access.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4_mem_access.sv
// stage4_mem_access: pipeline stage 4, the data-memory access stage.
// Takes one instruction from execute and issues at most one request on a
// req/ready/rvalid data-memory port. It produces the writeback value for
// stage 5. While a memory transaction is outstanding, mem_busy holds stages 1-3.
//
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   stall                      downstream stall (hold outputs, accept nothing)
//   valid, eval, store_data    stage-3 result, address/passthrough value, store data
//   mem_op, mem_size           00 none/01 load/10 store/11 none; byte/half/word/word
//   mem_unsigned, rd_in        zero-extend loads, destination register
//   dmem_*                     data-memory request/response port
//   mem_busy                   pipeline hold request
//   out_valid, out_rd, out_value   result to stage 5
//   misalign                   (only with MEM_MISALIGN_TRAP_EN) misaligned access trap
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned half and
// word accesses are trapped. When it is undefined, the low address bits are ignored.
module stage4_mem_access #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RD_BITS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               valid,
  input  logic [XLEN-1:0]    eval,
  input  logic [XLEN-1:0]    store_data,
  input  logic [1:0]         mem_op,
  input  logic [1:0]         mem_size,
  input  logic               mem_unsigned,
  input  logic [RD_BITS-1:0] rd_in,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ready,
  input  logic               dmem_rvalid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               mem_busy,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic               misalign,
`endif
  output logic               out_valid,
  output logic [RD_BITS-1:0] out_rd,
  output logic [XLEN-1:0]    out_value
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRd} state_e;

  state_e             state_q;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic               store_q;
  logic [RD_BITS-1:0] rd_q;

  logic            is_mem;
  logic            is_store;
  logic            trap;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_c;

  // Request decode from the incoming instruction.
  always_comb begin
    is_store = (mem_op == 2'b10);
    is_mem   = (mem_op == 2'b01) || is_store;
    unique case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << eval[1:0];
        wdata_c = {(XLEN/8){store_data[7:0]}};
      end
      2'b01: begin
        be_c    = eval[1] ? 4'b1100 : 4'b0011;
        wdata_c = {(XLEN/16){store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    trap = is_mem && (((mem_size == 2'b01) && eval[0]) ||
                      (mem_size[1] && (eval[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
  end

  // Lane extraction and extension of the returned load word.
  always_comb begin
    lane_b = dmem_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (size_q)
      2'b00:   load_c = {{(XLEN-8){lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_c = {{(XLEN-16){lane_h[15] & ~uns_q}}, lane_h};
      default: load_c = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      rd_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      mem_busy   <= 1'b0;
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_value  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Under stall the current result (if any) is held and nothing is accepted.
          if (!stall) begin
            out_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
            if (valid) begin
              off_q   <= eval[1:0];
              size_q  <= mem_size;
              uns_q   <= mem_unsigned;
              store_q <= is_store;
              rd_q    <= rd_in;
              if (trap) begin
                out_valid <= 1'b1;
                out_rd    <= '0;
                out_value <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
                misalign  <= 1'b1;
`endif
              end else if (is_mem) begin
                state_q    <= StReq;
                dmem_req   <= 1'b1;
                mem_busy   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {eval[XLEN-1:2], 2'b00};
                dmem_be    <= be_c;
                dmem_wdata <= wdata_c;
              end else begin
                out_valid <= 1'b1;
                out_value <= eval;
                out_rd    <= rd_in;
              end
            end
          end
        end
        StReq: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (store_q) begin
              state_q   <= StIdle;
              mem_busy  <= 1'b0;
              out_valid <= 1'b1;
              out_rd    <= '0;
              out_value <= '0;
            end else if (dmem_rvalid) begin
              // Data returned together with the accept: skip WAIT_RD.
              state_q   <= StIdle;
              mem_busy  <= 1'b0;
              out_valid <= 1'b1;
              out_rd    <= rd_q;
              out_value <= load_c;
            end else begin
              state_q <= StWaitRd;
            end
          end
        end
        StWaitRd: begin
          // Completion ignores stall: the result is registered, then held by stall in IDLE.
          if (dmem_rvalid) begin
            state_q   <= StIdle;
            mem_busy  <= 1'b0;
            out_valid <= 1'b1;
            out_rd    <= rd_q;
            out_value <= load_c;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stage4_mem_access.sv
// Directed bench for stage4_mem_access. A behavioural transaction model predicts
// every output each cycle, and hand-computed literals pin the key results.
module tb_stage4_mem_access;

  logic        clock = 1'b0;
  logic        reset, stall, valid, mem_unsigned;
  logic [31:0] eval, store_data, dmem_rdata;
  logic [1:0]  mem_op, mem_size;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid, mem_busy, out_valid;
  logic [31:0] dmem_addr, dmem_wdata, out_value;
  logic [3:0]  dmem_be;
  logic [4:0]  out_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  stage4_mem_access dut (
    .clock(clock), .reset(reset), .stall(stall), .valid(valid), .eval(eval),
    .store_data(store_data), .mem_op(mem_op), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .rd_in(rd_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_busy(mem_busy),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .out_valid(out_valid), .out_rd(out_rd), .out_value(out_value)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ld_model(input logic [1:0] a, input logic [1:0] size,
                                           input logic uns, input logic [31:0] word);
    int nbits;
    logic [31:0] v, mask;
    if (size >= 2) return word;
    nbits = (size == 0) ? 8 : 16;
    v     = (size == 0) ? (word >> (8 * a)) : (word >> (16 * (a / 2)));
    mask  = (32'h1 << nbits) - 1;
    if (!uns && v[nbits-1]) return (v & mask) | ~mask;
    return v & mask;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] size, input logic [1:0] a);
    if (size == 0) return 4'(1 << a);
    if (size == 1) return 4'(3 << (a & 2'b10));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(input logic [1:0] size, input logic [31:0] sd);
    if (size == 0) return {24'h0, sd[7:0]} * 32'h0101_0101;
    if (size == 1) return {16'h0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  // Outstanding transaction and expected outputs.
  bit          m_act, m_issued, m_load, m_uns;
  logic [1:0]  m_a, m_size;
  logic [4:0]  m_rd;
  bit          e_ov, e_busy, e_req, e_we, e_mis, e_chkval;
  logic [31:0] e_val, e_addr, e_wdata;
  logic [4:0]  e_rd;
  logic [3:0]  e_be;

  task automatic finish(input bit is_load);
    m_act  = 0;
    e_busy = 0;
    e_req  = 0;
    e_ov   = 1;
    if (is_load) begin
      e_rd     = m_rd;
      e_val    = ld_model(m_a, m_size, m_uns, dmem_rdata);
      e_chkval = 1;
    end else begin
      e_rd     = 0;
      e_chkval = 0;
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_act = 0; m_issued = 0;
      e_ov = 0; e_busy = 0; e_req = 0; e_we = 0; e_mis = 0; e_chkval = 1;
      e_val = 0; e_addr = 0; e_wdata = 0; e_rd = 0; e_be = 0;
    end else if (m_act) begin
      if (!m_issued) begin
        if (dmem_ready) begin
          e_req = 0;
          if (!m_load) finish(0);
          else if (dmem_rvalid) finish(1);
          else m_issued = 1;
        end
      end else if (dmem_rvalid) begin
        finish(1);
      end
    end else if (!stall) begin
      e_ov  = 0;
      e_mis = 0;
      if (valid) begin
        if (mem_op == 2'd1 || mem_op == 2'd2) begin
          if (TrapEn && ((mem_size == 1 && eval[0]) || (mem_size >= 2 && eval[1:0] != 0))) begin
            e_ov = 1; e_rd = 0; e_mis = 1; e_chkval = 0;
          end else begin
            m_act = 1; m_issued = 0; m_load = (mem_op == 2'd1);
            m_a = eval[1:0]; m_size = mem_size; m_uns = mem_unsigned; m_rd = rd_in;
            e_req = 1; e_busy = 1; e_we = !m_load;
            e_addr = eval & ~32'h3;
            e_be = be_model(mem_size, eval[1:0]);
            e_wdata = wd_model(mem_size, store_data);
          end
        end else begin
          e_ov = 1; e_val = eval; e_rd = rd_in; e_chkval = 1;
        end
      end
    end
  end

  // Single compare process, on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_out_valid", out_valid, e_ov);
      check("m_mem_busy", mem_busy, e_busy);
      check("m_dmem_req", dmem_req, e_req);
      if (e_ov) begin
        check("m_out_rd", out_rd, e_rd);
        if (e_chkval) check("m_out_value", out_value, e_val);
      end
      if (e_req) begin
        check("m_dmem_addr", dmem_addr, e_addr);
        check("m_dmem_be", dmem_be, e_be);
        check("m_dmem_we", dmem_we, e_we);
        if (e_we) check("m_dmem_wdata", dmem_wdata, e_wdata);
      end
`ifdef MEM_MISALIGN_TRAP_EN
      check("m_misalign", misalign, e_mis);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [1:0] o, input logic [1:0] s, input logic u,
                    input logic [31:0] e, input logic [31:0] sd, input logic [4:0] rd);
    valid = 1; mem_op = o; mem_size = s; mem_unsigned = u; eval = e; store_data = sd;
    rd_in = rd;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_dmem_req"}, dmem_req, 0);
    check({tag, "_dmem_we"}, dmem_we, 0);
    check({tag, "_mem_busy"}, mem_busy, 0);
    check({tag, "_dmem_be"}, dmem_be, 0);
    check({tag, "_out_value"}, out_value, 0);
    check({tag, "_out_rd"}, out_rd, 0);
    check({tag, "_dmem_addr"}, dmem_addr, 0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 0);
  endtask

  // Load through the port: data with the accept (same=1), or one cycle later.
  task automatic do_load(input logic [1:0] s, input logic u, input logic [31:0] e,
                         input logic [4:0] rd, input logic [31:0] rdata, input bit same,
                         input logic [31:0] exp);
    op(2'd1, s, u, e, 32'h0, rd);
    tick();
    valid = 0;
    @(negedge clock);
    check("ld_req", dmem_req, 1);
    dmem_ready = 1; dmem_rvalid = same; dmem_rdata = rdata;
    tick();
    dmem_ready = 0;
    if (!same) begin
      dmem_rvalid = 1;
      tick();
    end
    dmem_rvalid = 0;
    @(negedge clock);
    check("ld_out_valid", out_valid, 1);
    check("ld_out_value", out_value, exp);
    check("ld_out_rd", out_rd, rd);
    check("ld_busy", mem_busy, 0);
    tick();
  endtask

  initial begin
    reset = 1; stall = 0; valid = 0; mem_op = 0; mem_size = 0; mem_unsigned = 0;
    eval = 0; store_data = 0; rd_in = 0; dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    tick();
    chk_en = 1;
    tick();
    @(negedge clock);
    check_zero_outputs("rst");
    reset = 0;
    tick();

    // Non-memory op and reserved op.
    op(2'd0, 2'd0, 0, 32'h1234, 32'h0, 5'd5);
    tick();
    op(2'd3, 2'd2, 0, 32'h55, 32'h0, 5'd7);
    @(negedge clock);
    check("nm_valid", out_valid, 1);
    check("nm_value", out_value, 32'h1234);
    check("nm_rd", out_rd, 5);
    check("nm_req", dmem_req, 0);
    tick();
    valid = 0;
    @(negedge clock);
    check("rsv_value", out_value, 32'h55);
    check("rsv_rd", out_rd, 7);
    tick();
    @(negedge clock);
    check("bubble", out_valid, 0);

    // SB at 0x103 with two wait states.
    op(2'd2, 2'd0, 0, 32'h103, 32'hAB, 5'd1);
    tick();
    valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("sb_req", dmem_req, 1);
      check("sb_addr", dmem_addr, 32'h100);
      check("sb_be", dmem_be, 4'b1000);
      check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      check("sb_busy", mem_busy, 1);
      if (i == 2) dmem_ready = 1;
      tick();
    end
    dmem_ready = 0;
    @(negedge clock);
    check("sb_done", out_valid, 1);
    check("sb_rd", out_rd, 0);
    check("sb_req_drop", dmem_req, 0);
    check("sb_busy_drop", mem_busy, 0);
    tick();

    // SH at 0x12, accepted immediately.
    op(2'd2, 2'd1, 0, 32'h12, 32'h5678_1234, 5'd2);
    tick();
    valid = 0;
    dmem_ready = 1;
    @(negedge clock);
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    tick();
    dmem_ready = 0;
    tick();

    // Loads.
    do_load(2'd1, 0, 32'h202, 5'd3, 32'h8001_0000, 0, 32'hFFFF_8001);
    do_load(2'd1, 1, 32'h202, 5'd3, 32'h8001_0000, 0, 32'h0000_8001);
    do_load(2'd0, 0, 32'h200, 5'd10, 32'h1234_56F0, 1, 32'hFFFF_FFF0);
    do_load(2'd0, 1, 32'h203, 5'd11, 32'h9A00_0000, 0, 32'h0000_009A);
    do_load(2'd1, 0, 32'h200, 5'd12, 32'h0000_7FFF, 1, 32'h0000_7FFF);
    do_load(2'd3, 0, 32'h204, 5'd2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
`ifndef MEM_MISALIGN_TRAP_EN
    do_load(2'd2, 0, 32'h101, 5'd13, 32'h1122_3344, 0, 32'h1122_3344);
`endif

    // LW with ready and rvalid together, and a back-to-back op in the result cycle.
    op(2'd1, 2'd2, 0, 32'h300, 32'h0, 5'd9);
    tick();
    valid = 0;
    dmem_ready = 1; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check("lw_req", dmem_req, 1);
    tick();
    dmem_ready = 0; dmem_rvalid = 0;
    op(2'd0, 2'd0, 0, 32'h77, 32'h0, 5'd4);
    @(negedge clock);
    check("lw_valid", out_valid, 1);
    check("lw_value", out_value, 32'hDEAD_BEEF);
    check("lw_rd", out_rd, 9);
    check("lw_busy", mem_busy, 0);
    tick();
    valid = 0;
    @(negedge clock);
    check("b2b_valid", out_valid, 1);
    check("b2b_value", out_value, 32'h77);
    check("b2b_rd", out_rd, 4);
    tick();

    // LB result arriving under a 3-cycle stall.
    op(2'd1, 2'd0, 0, 32'h401, 32'h0, 5'd6);
    tick();
    valid = 0;
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h0000_8000; stall = 1;
    tick();
    dmem_rvalid = 0;
    op(2'd0, 2'd0, 0, 32'h99, 32'h0, 5'd7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("stl_valid", out_valid, 1);
      check("stl_value", out_value, 32'hFFFF_FF80);
      check("stl_rd", out_rd, 6);
      tick();
    end
    stall = 0; valid = 0;
    @(negedge clock);
    check("stl_valid3", out_valid, 1);
    check("stl_value3", out_value, 32'hFFFF_FF80);
    tick();
    @(negedge clock);
    check("stl_no_second", out_valid, 0);
    tick();

    // Reset while waiting for read data; a late rvalid is ignored.
    op(2'd1, 2'd2, 0, 32'h500, 32'h0, 5'd8);
    tick();
    valid = 0;
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    @(negedge clock);
    check_zero_outputs("midrst");
    dmem_rvalid = 1; dmem_rdata = 32'h1234;
    tick();
    dmem_rvalid = 0;
    @(negedge clock);
    check("late_rvalid", out_valid, 0);
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    op(2'd1, 2'd2, 0, 32'h101, 32'h0, 5'd8);
    tick();
    valid = 0;
    @(negedge clock);
    check("mis_req", dmem_req, 0);
    check("mis_valid", out_valid, 1);
    check("mis_flag", misalign, 1);
    check("mis_rd", out_rd, 0);
    tick();
    @(negedge clock);
    check("mis_clear", misalign, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
